sr_ff_bank: RTL and testbench



---
 rtl/sr_ff_bank.sv | 135 +++++++++++++
 tb/tb_sr_ff_bank.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/sr_ff_bank.sv
// ---------------------------------------------------------------------------
// sr_ff_bank
// Bank of WIDTH independent clocked set/reset flip-flops. These serve as
// general-purpose sticky status flags under one clock. Each channel has a
// clock enable, a synchronous reset and a selectable policy for S and R
// arriving together. An optional edge-sensitive input mode is available.
// The bank also reports per-bit change pulses and keeps a saturating count
// of edges on which any channel saw an S/R conflict.
//
// Parameters
//   WIDTH         number of SR channels
//   CONFLICT_MODE 0 set-dominant, 1 reset-dominant, 2 hold, 3 toggle
//   EDGE_MODE     0 level-sensitive S/R, 1 rising transitions only
//   RESET_VALUE   value loaded into q on reset
//   CNT_W         width of the conflict counter
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   en           clock enable for q, edge history and pulses
//   s, r         per-channel set / reset requests
//   cnt_clr      synchronous clear of conflict_cnt
//   q, q_n       flip-flop state and its inverse
//   changed      one-cycle pulse per bit that flipped on the last edge
//   conflict     one-cycle pulse if any bit had S and R both active
//   conflict_cnt saturating count of conflict edges
// ---------------------------------------------------------------------------
module sr_ff_bank #(
   parameter int               WIDTH         = 8,
   parameter int               CONFLICT_MODE = 0,
   parameter int               EDGE_MODE     = 0,
   parameter logic [WIDTH-1:0] RESET_VALUE   = '0,
   parameter int               CNT_W         = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [WIDTH-1:0] s,
   input  logic [WIDTH-1:0] r,
   input  logic             cnt_clr,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] q_n,
   output logic [WIDTH-1:0] changed,
   output logic             conflict,
   output logic [CNT_W-1:0] conflict_cnt
);

   localparam logic [CNT_W-1:0] CntMax = '1;

   logic [WIDTH-1:0] r_q;
   logic [WIDTH-1:0] r_sPrev;
   logic [WIDTH-1:0] r_rPrev;
   logic [WIDTH-1:0] r_changed;
   logic             r_conflict;
   logic [CNT_W-1:0] r_cnt;

   logic [WIDTH-1:0] w_se;
   logic [WIDTH-1:0] w_re;
   logic [WIDTH-1:0] w_conf;
   logic [WIDTH-1:0] w_confVal;
   logic [WIDTH-1:0] w_qNext;
   logic             w_anyConf;

   // Effective requests. In edge mode only a request that was low on the
   // previous enabled sample counts. Because the history resets to zero, a
   // request already high out of reset is seen as an edge.
   always_comb begin
      w_se = s;
      w_re = r;
      if (EDGE_MODE != 0) begin
         w_se = s & ~r_sPrev;
         w_re = r & ~r_rPrev;
      end
   end

   // Value taken by a bit whose set and reset are both active.
   always_comb begin
      w_confVal = '1;
      case (CONFLICT_MODE)
         1:       w_confVal = '0;
         2:       w_confVal = r_q;
         3:       w_confVal = ~r_q;
         default: w_confVal = '1;
      endcase
   end

   // Next state. Each bit falls into exactly one of hold, set, reset or
   // conflict, so these terms never overlap.
   always_comb begin
      w_conf    = w_se & w_re;
      w_anyConf = |w_conf;
      w_qNext   = (r_q & ~w_se & ~w_re) | (w_se & ~w_re) | (w_conf & w_confVal);
   end

   // Flag state, edge history and pulses. A disabled cycle holds state and
   // drops the pulses. Reset drops them as well, so the jump to
   // RESET_VALUE never shows up in changed.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_q        <= RESET_VALUE;
         r_sPrev    <= '0;
         r_rPrev    <= '0;
         r_changed  <= '0;
         r_conflict <= 1'b0;
      end else if (en) begin
         r_q        <= w_qNext;
         r_sPrev    <= s;
         r_rPrev    <= r;
         r_changed  <= w_qNext ^ r_q;
         r_conflict <= w_anyConf;
      end else begin
         r_changed  <= '0;
         r_conflict <= 1'b0;
      end
   end

   // Conflict counter. A clear wins over a coincident increment, and the
   // count sticks at its maximum instead of wrapping.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (cnt_clr) begin
         r_cnt <= '0;
      end else if (en && w_anyConf && (r_cnt != CntMax)) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   assign q            = r_q;
   assign q_n          = ~r_q;
   assign changed      = r_changed;
   assign conflict     = r_conflict;
   assign conflict_cnt = r_cnt;

endmodule

// File: tb/tb_sr_ff_bank.sv
// ---------------------------------------------------------------------------
// tb_sr_ff_bank
// Five sr_ff_bank instances share one stimulus stream. Instances 0..3 are
// level-sensitive and use conflict policies 0..3, RESET_VALUE 8'hA5 and a
// 2-bit counter. Instance 4 is edge-sensitive and uses the toggle policy,
// RESET_VALUE 0 and an 8-bit counter. The driver applies each input vector
// and queues the behaviour expected after the next edge. The monitor pops
// one entry per edge and compares every instance against it.
// ---------------------------------------------------------------------------
module tb_sr_ff_bank;

   localparam int NDut = 5;

   typedef struct packed {
      logic [NDut-1:0][7:0] q;
      logic [NDut-1:0][7:0] chg;
      logic [NDut-1:0]      conf;
      logic [NDut-1:0][7:0] cnt;
   } expT;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en = 1'b0;
   logic [7:0] s = 8'h00;
   logic [7:0] r = 8'h00;
   logic       cntClr = 1'b0;

   logic [7:0] dQ    [NDut];
   logic [7:0] dQn   [NDut];
   logic [7:0] dChg  [NDut];
   logic       dConf [NDut];
   logic [1:0] dCnt2 [4];
   logic [7:0] dCntE;

   expT sb[$];
   int  checks = 0;
   int  errors = 0;
   int  edgeNo = 0;

   // Reference state: one flag byte, request history and counter per instance.
   logic [7:0] mQ  [NDut];
   logic [7:0] mPs [NDut];
   logic [7:0] mPr [NDut];
   int         mCnt[NDut];

   always #5 clk = ~clk;

   for (genvar g = 0; g < 4; g++) begin : gLevel
      sr_ff_bank #(.WIDTH(8), .CONFLICT_MODE(g), .EDGE_MODE(0),
                   .RESET_VALUE(8'hA5), .CNT_W(2)) uDut (
         .clk(clk), .rst(rst), .en(en), .s(s), .r(r), .cnt_clr(cntClr),
         .q(dQ[g]), .q_n(dQn[g]), .changed(dChg[g]), .conflict(dConf[g]),
         .conflict_cnt(dCnt2[g]));
   end

   sr_ff_bank #(.WIDTH(8), .CONFLICT_MODE(3), .EDGE_MODE(1),
                .RESET_VALUE(8'h00), .CNT_W(8)) uEdge (
      .clk(clk), .rst(rst), .en(en), .s(s), .r(r), .cnt_clr(cntClr),
      .q(dQ[4]), .q_n(dQn[4]), .changed(dChg[4]), .conflict(dConf[4]),
      .conflict_cnt(dCntE));

   function automatic int cfgMode(int d);
      return (d < 4) ? d : 3;
   endfunction

   function automatic logic [7:0] cfgReset(int d);
      return (d < 4) ? 8'hA5 : 8'h00;
   endfunction

   function automatic int cfgCntMax(int d);
      return (d < 4) ? 3 : 255;
   endfunction

   // Advance the reference by one clock edge and return what the outputs
   // must show afterwards.
   function automatic expT modelStep(logic iRst, logic iEn, logic [7:0] iS,
                                     logic [7:0] iR, logic iClr);
      expT e;
      e = '0;
      for (int d = 0; d < NDut; d++) begin
         logic [7:0] se, re, nq;
         logic       anyConf;
         if (iRst) begin
            mQ[d] = cfgReset(d);
            mPs[d] = 8'h00;
            mPr[d] = 8'h00;
            mCnt[d] = 0;
         end else begin
            se = (d == 4) ? (iS & ~mPs[d]) : iS;
            re = (d == 4) ? (iR & ~mPr[d]) : iR;
            anyConf = 1'b0;
            nq = mQ[d];
            if (iEn) begin
               for (int i = 0; i < 8; i++) begin
                  if (se[i] && !re[i]) nq[i] = 1'b1;
                  else if (!se[i] && re[i]) nq[i] = 1'b0;
                  else if (se[i] && re[i]) begin
                     anyConf = 1'b1;
                     case (cfgMode(d))
                        0: nq[i] = 1'b1;
                        1: nq[i] = 1'b0;
                        2: nq[i] = mQ[d][i];
                        default: nq[i] = ~mQ[d][i];
                     endcase
                  end
               end
               e.chg[d] = nq ^ mQ[d];
               e.conf[d] = anyConf;
               mQ[d] = nq;
               mPs[d] = iS;
               mPr[d] = iR;
            end
            if (iClr) mCnt[d] = 0;
            else if (anyConf && mCnt[d] < cfgCntMax(d)) mCnt[d] = mCnt[d] + 1;
         end
         e.q[d] = mQ[d];
         e.cnt[d] = 8'(mCnt[d]);
      end
      return e;
   endfunction

   // Drive one input vector and queue the response expected after the edge.
   task automatic applyStimulus(input logic iRst, input logic iEn,
                                input logic [7:0] iS, input logic [7:0] iR,
                                input logic iClr);
      @(negedge clk);
      rst = iRst;
      en = iEn;
      s = iS;
      r = iR;
      cntClr = iClr;
      sb.push_back(modelStep(iRst, iEn, iS, iR, iClr));
   endtask

   task automatic checkOutput(input string name, input int d,
                              input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s dut%0d edge %0d: actual %h expected %h",
                  name, d, edgeNo, act, exp);
      end
   endtask

   // Monitor: one scoreboard entry per edge, sampled just after it.
   initial begin
      expT e;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() != 0) begin
            e = sb.pop_front();
            edgeNo++;
            for (int d = 0; d < NDut; d++) begin
               checkOutput("q", d, dQ[d], e.q[d]);
               checkOutput("q_n", d, dQn[d], ~e.q[d]);
               checkOutput("changed", d, dChg[d], e.chg[d]);
               checkOutput("conflict", d, {7'd0, dConf[d]}, {7'd0, e.conf[d]});
               checkOutput("conflict_cnt", d,
                           (d < 4) ? {6'd0, dCnt2[d]} : dCntE, e.cnt[d]);
            end
         end
      end
   end

   initial begin
      // Reset with set requests active.
      applyStimulus(1, 1, 8'hFF, 8'h00, 0);
      applyStimulus(1, 1, 8'hFF, 8'h00, 0);
      // Level set, then reset, then a disabled cycle.
      applyStimulus(0, 1, 8'h0F, 8'h00, 0);
      applyStimulus(0, 1, 8'h00, 8'h03, 0);
      applyStimulus(0, 0, 8'hF0, 8'h00, 0);
      // Clear bit 0 and the counters, then hold a bit-0 conflict for 3 edges.
      applyStimulus(0, 1, 8'h00, 8'h01, 1);
      for (int k = 0; k < 3; k++) applyStimulus(0, 1, 8'h01, 8'h01, 0);
      // Further conflicts saturate the 2-bit counters. A final clear then
      // arrives together with a conflict.
      for (int k = 0; k < 3; k++) applyStimulus(0, 1, 8'h01, 8'h01, 0);
      applyStimulus(0, 1, 8'h01, 8'h01, 1);
      // Edge detection: s held, r pulsed, then a repeat s across en=0.
      applyStimulus(1, 0, 8'h00, 8'h00, 0);
      for (int k = 0; k < 4; k++) applyStimulus(0, 1, 8'h01, 8'h00, 0);
      applyStimulus(0, 1, 8'h00, 8'h01, 0);
      applyStimulus(0, 1, 8'h00, 8'h00, 0);
      applyStimulus(0, 0, 8'h01, 8'h00, 0);
      applyStimulus(0, 1, 8'h01, 8'h00, 0);
      // Continuous toggle conflict interrupted by a one-cycle reset.
      for (int k = 0; k < 3; k++) applyStimulus(0, 1, 8'h01, 8'h01, 0);
      applyStimulus(1, 1, 8'h01, 8'h01, 0);
      for (int k = 0; k < 3; k++) applyStimulus(0, 1, 8'h01, 8'h01, 0);
      // Random traffic with frequent conflicts and occasional clears/resets.
      for (int k = 0; k < 400; k++) begin
         logic [7:0] rs, rr;
         rs = 8'($urandom);
         rr = 8'($urandom);
         if ($urandom_range(0, 3) == 0) rr = rr | rs;
         applyStimulus($urandom_range(0, 39) == 0, $urandom_range(0, 4) != 0,
                       rs, rr, $urandom_range(0, 9) == 0);
      end
      applyStimulus(0, 0, 8'h00, 8'h00, 0);
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("[TB] FAIL scoreboard_drain: actual %0d entries left, expected 0",
                  sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
